// File: rtl/axis_frame_filter_fwd.sv
// Store-and-forward AXI-Stream framer: parses SOP/ID/LEN/payload/EOP, forwards only
// well-formed frames from a single payload buffer, drops malformed ones with resync on tlast.
//
// RX state | meaning
// ---------+---------------------------------------------------------------
// RX_SOP   | waiting for the start-of-packet marker
// RX_ID    | next accepted word is the frame ID
// RX_LEN   | next accepted word is the payload length
// RX_DATA  | writing payload words into the buffer
// RX_EOP   | expecting the end-of-packet marker with tlast
// RX_DROP  | discarding a malformed frame until tlast
// RX_HOLD  | frame buffered, input stalled until the TX side finishes
//
// TX state | meaning
// ---------+---------------------------------------------------------------
// TX_IDLE  | nothing to send
// TX_HID   | presenting the ID header word
// TX_HLEN  | presenting the LEN header word
// TX_PAY   | presenting payload words from the buffer
module axis_frame_filter_fwd #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    MAX_LEN    = 64,
    parameter logic [DATA_WIDTH-1:0] SOP_WORD   = 16'h0A0A,
    parameter logic [DATA_WIDTH-1:0] EOP_WORD   = 16'h0B0B,
    parameter bit                    FWD_HDR    = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m_frame_id,
    output logic [15:0]               frames_ok,
    output logic [15:0]               frames_err,
    output logic                      err_pulse,
    output logic [2:0]                err_code
);

    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_SOP = 3'd1;
    localparam logic [2:0] ERR_TRUNC   = 3'd2;
    localparam logic [2:0] ERR_BAD_LEN = 3'd3;
    localparam logic [2:0] ERR_BAD_EOP = 3'd4;
    localparam logic [2:0] ERR_NO_LAST = 3'd5;

    typedef enum logic [2:0] {
        RX_SOP, RX_ID, RX_LEN, RX_DATA, RX_EOP, RX_DROP, RX_HOLD
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_HID, TX_HLEN, TX_PAY
    } tx_state_t;

    rx_state_t rx_state, rx_next;
    tx_state_t tx_state, tx_next;

    logic [DATA_WIDTH-1:0] buf_mem [MAX_LEN];
    logic [DATA_WIDTH-1:0] id_q;
    logic [DATA_WIDTH-1:0] len_q;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      last_idx;

    logic       rx_acc, tx_fire, wr_last, rd_last, tx_done, len_bad;
    logic       id_load, len_load, wr_en, tx_start, err_set;
    logic [2:0] err_val;

    logic unused_tkeep;
    assign unused_tkeep = ^s_axis_tkeep;

    assign s_axis_tready = (rx_state != RX_HOLD);
    assign rx_acc        = s_axis_tvalid && s_axis_tready;
    assign tx_fire       = m_axis_tvalid && m_axis_tready;
    assign wr_last       = (wr_cnt == last_idx);
    assign rd_last       = (rd_cnt == last_idx);
    assign tx_done       = tx_fire && (tx_state == TX_PAY) && rd_last;
    assign len_bad       = (s_axis_tdata == '0) || (s_axis_tdata > DATA_WIDTH'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_SOP;
            tx_state <= TX_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    always_comb begin
        rx_next  = rx_state;
        err_set  = 1'b0;
        err_val  = ERR_NONE;
        id_load  = 1'b0;
        len_load = 1'b0;
        wr_en    = 1'b0;
        tx_start = 1'b0;
        if (rx_acc) begin
            case (rx_state)
                RX_SOP: begin
                    if (s_axis_tdata == SOP_WORD) begin
                        if (s_axis_tlast) begin
                            err_set = 1'b1;
                            err_val = ERR_TRUNC;
                        end else begin
                            rx_next = RX_ID;
                        end
                    end else begin
                        err_set = 1'b1;
                        err_val = ERR_BAD_SOP;
                        rx_next = s_axis_tlast ? RX_SOP : RX_DROP;
                    end
                end
                RX_ID: begin
                    if (s_axis_tlast) begin
                        err_set = 1'b1;
                        err_val = ERR_TRUNC;
                        rx_next = RX_SOP;
                    end else begin
                        id_load = 1'b1;
                        rx_next = RX_LEN;
                    end
                end
                RX_LEN: begin
                    // A bad length outranks truncation so the cause reported is the header fault.
                    if (len_bad) begin
                        err_set = 1'b1;
                        err_val = ERR_BAD_LEN;
                        rx_next = s_axis_tlast ? RX_SOP : RX_DROP;
                    end else if (s_axis_tlast) begin
                        err_set = 1'b1;
                        err_val = ERR_TRUNC;
                        rx_next = RX_SOP;
                    end else begin
                        len_load = 1'b1;
                        rx_next  = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (s_axis_tlast) begin
                        err_set = 1'b1;
                        err_val = ERR_TRUNC;
                        rx_next = RX_SOP;
                    end else begin
                        wr_en = 1'b1;
                        if (wr_last) rx_next = RX_EOP;
                    end
                end
                RX_EOP: begin
                    if (s_axis_tdata != EOP_WORD) begin
                        err_set = 1'b1;
                        err_val = ERR_BAD_EOP;
                        rx_next = s_axis_tlast ? RX_SOP : RX_DROP;
                    end else if (s_axis_tlast) begin
                        tx_start = 1'b1;
                        rx_next  = RX_HOLD;
                    end else begin
                        err_set = 1'b1;
                        err_val = ERR_NO_LAST;
                        rx_next = RX_DROP;
                    end
                end
                RX_DROP: begin
                    if (s_axis_tlast) rx_next = RX_SOP;
                end
                default: rx_next = RX_SOP;
            endcase
        end
        if (tx_done) rx_next = RX_SOP;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_start) tx_next = FWD_HDR ? TX_HID : TX_PAY;
            TX_HID:  if (tx_fire) tx_next = TX_HLEN;
            TX_HLEN: if (tx_fire) tx_next = TX_PAY;
            TX_PAY:  if (tx_done) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_mem[wr_cnt[ADDR_W-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_q       <= '0;
            len_q      <= '0;
            last_idx   <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            frames_ok  <= '0;
            frames_err <= '0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            err_pulse <= err_set;
            if (err_set) begin
                err_code <= err_val;
                if (frames_err != 16'hFFFF) frames_err <= frames_err + 16'd1;
            end
            if (tx_done && frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
            if (id_load) id_q <= s_axis_tdata;
            if (len_load) begin
                len_q    <= s_axis_tdata;
                last_idx <= CNT_W'(s_axis_tdata - 1'b1);
                wr_cnt   <= '0;
            end else if (wr_en) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if (tx_start) rd_cnt <= '0;
            else if (tx_fire && tx_state == TX_PAY) rd_cnt <= rd_cnt + CNT_W'(1);
        end
    end

    // Outputs derive only from TX state and registers, so they hold while stalled.
    always_comb begin
        case (tx_state)
            TX_HID:  m_axis_tdata = id_q;
            TX_HLEN: m_axis_tdata = len_q;
            TX_PAY:  m_axis_tdata = buf_mem[rd_cnt[ADDR_W-1:0]];
            default: m_axis_tdata = '0;
        endcase
    end

    assign m_axis_tvalid = (tx_state != TX_IDLE);
    assign m_axis_tlast  = (tx_state == TX_PAY) && rd_last;
    assign m_axis_tkeep  = {(DATA_WIDTH/8){m_axis_tvalid}};
    assign m_frame_id    = m_axis_tvalid ? id_q : '0;

endmodule
